// File: rtl/bit_stream_serializer_if.sv
// Parallel-in / serial-out bundle for the bit stream serializer.
// master = word producer and stream consumer, slave = serializer.
interface bit_stream_serializer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic             ENABLE;
  logic             S_output;
  logic             S_valid;
  logic             WORD_START;
  logic             WORD_DONE;
  logic [LW-1:0]    LEVEL;

  modport master (
    output IN_DATA, IN_VALID, ENABLE,
    input  IN_READY, S_output, S_valid, WORD_START, WORD_DONE, LEVEL
  );

  modport slave (
    input  IN_DATA, IN_VALID, ENABLE,
    output IN_READY, S_output, S_valid, WORD_START, WORD_DONE, LEVEL
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Word FIFO feeding a shift register that emits framed, gap-free serial bits
// for the 1011 sequence detector.
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input logic                    CLK,
  input logic                    RST,
  bit_stream_serializer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic [WIDTH-1:0] head_c;
  logic             in_ready_c, push_c, pop_c;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             s_out_q, s_out_d;
  logic             s_valid_q, s_valid_d;
  logic             start_q, start_d;
  logic             done_q, done_d;

  // No bypass: readiness depends only on the registered occupancy.
  assign in_ready_c = RST && (count_q < LW'(DEPTH));
  assign push_c     = bus.IN_VALID && in_ready_c;
  assign head_c     = mem[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (push_c) mem[wr_ptr_q] <= bus.IN_DATA;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_c && !pop_c)      count_q <= count_q + LW'(1);
      else if (pop_c && !push_c) count_q <= count_q - LW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      s_out_q   <= IDLE_BIT;
      s_valid_q <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      start_q   <= start_d;
      done_q    <= done_d;
    end
  end

  // Everything holds by default, which is exactly the stall behaviour.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    s_out_d   = s_out_q;
    s_valid_d = s_valid_q;
    start_d   = start_q;
    done_d    = done_q;
    pop_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ENABLE && (count_q != '0)) pop_c = 1'b1;
      end
      SHIFT: begin
        if (bus.ENABLE) begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - CW'(1);
            s_out_d   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
            sh_d      = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
            start_d   = 1'b0;
            done_d    = (bit_cnt_q == CW'(1));
          end else if (count_q != '0) begin
            pop_c = 1'b1;
          end else begin
            state_d   = IDLE;
            s_valid_d = 1'b0;
            s_out_d   = IDLE_BIT;
            start_d   = 1'b0;
            done_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading a word presents its first bit immediately; sh keeps the remainder.
    if (pop_c) begin
      state_d   = SHIFT;
      bit_cnt_d = CW'(WIDTH - 1);
      s_out_d   = MSB_FIRST ? head_c[WIDTH-1] : head_c[0];
      sh_d      = MSB_FIRST ? (head_c << 1) : (head_c >> 1);
      s_valid_d = 1'b1;
      start_d   = 1'b1;
      done_d    = 1'b0;
    end
  end

  assign bus.IN_READY   = in_ready_c;
  assign bus.S_output   = s_out_q;
  assign bus.S_valid    = s_valid_q;
  assign bus.WORD_START = start_q;
  assign bus.WORD_DONE  = done_q;
  assign bus.LEVEL      = count_q;
endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
Upstream feeder for the 1011 sequence detector. It accepts parallel words through a valid/ready handshake and buffers them in a small FIFO. It then shifts each word out one bit per clock on a serial line that drives the detector's S_input. Used in integration benches and on-board stimulus paths to supply gap-free, framed bit streams to the detector.

Parameters:
WIDTH, 4, bits per word; legal range is 2 or more.
DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2.
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
IDLE_BIT, 0, value driven on S_output whenever S_valid=0.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-low reset (0 = reset asserted).
IN_DATA  input  WIDTH  word to enqueue.
IN_VALID  input  1  IN_DATA is valid this cycle.
IN_READY  output  1  FIFO can accept a word this cycle.
ENABLE  input  1  shift enable; 0 stalls the serial side.
S_output  output  1  serial bit; connects to the detector's S_input.
S_valid  output  1  S_output carries a word bit.
WORD_START  output  1  high while the first bit of a word is presented.
WORD_DONE  output  1  high while the last bit of a word is presented.
LEVEL  output  clog2(DEPTH)+1  number of words in the FIFO; excludes the word in the shifter.

Behaviour:
- Reset (RST=0, asynchronous):
  - FIFO is emptied; LEVEL=0.
  - S_valid=0, S_output=IDLE_BIT, WORD_START=0, WORD_DONE=0.
  - The state machine goes to IDLE.
  - IN_READY=0 while RST=0.
- Reset mid-word aborts the word. The partial word and all FIFO contents are discarded; no WORD_DONE is produced.
- Push:
  - IN_READY = RST && (LEVEL < DEPTH). It is combinational from the registered count and has no bypass.
  - A word is enqueued at the edge where IN_VALID && IN_READY.
  - When LEVEL=DEPTH, IN_READY=0 even if a pop occurs in the same cycle.
- The FIFO uses circular read/write pointers that wrap modulo DEPTH.
  - Simultaneous push and pop leaves LEVEL unchanged.
  - LEVEL never exceeds DEPTH or goes below 0.
- State IDLE:
  - S_valid=0 and S_output=IDLE_BIT.
  - If LEVEL>0 and ENABLE=1 at an edge: pop the head word into the shift register, set bit_cnt=WIDTH-1, go to SHIFT.
  - After that edge: S_valid=1, S_output = first bit, WORD_START=1.
- State SHIFT:
  - Each edge with ENABLE=1 and bit_cnt>0 presents the next bit and decrements bit_cnt.
  - WORD_START=0 after the first bit.
  - WORD_DONE=1 while bit_cnt=0, i.e. while the last bit is presented.
- Last bit (bit_cnt=0), edge with ENABLE=1:
  - If LEVEL>0: load the next word back-to-back. There is no idle cycle and WORD_START=1 on the following cycle.
  - Else: go to IDLE and drop S_valid.
- Stall (ENABLE=0): S_output, S_valid, WORD_START, WORD_DONE and bit_cnt all hold. Pushes still proceed.
- Bit order:
  - MSB_FIRST=1: bits IN_DATA[WIDTH-1] down to IN_DATA[0].
  - MSB_FIRST=0: the reverse order.
- Latency: a word pushed into an empty FIFO at edge n, with the shifter IDLE and ENABLE=1, has its first bit on S_output after edge n+1.
- All outputs except IN_READY are registered.

Test Plan:
1. WIDTH=4, ENABLE=1; push 4'b1011 once.
   - Required: S_output = 1,0,1,1 on four consecutive cycles with S_valid=1.
   - WORD_START on cycle 1 only; WORD_DONE on cycle 4 only; then S_valid=0 and S_output=0.
   - Attached detector asserts D_output.
2. Push 4'b1011 then 4'b0110 on consecutive cycles.
   - Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0 with no gap.
   - WORD_START pulses on bits 1 and 5; WORD_DONE pulses on bits 4 and 8.
3. ENABLE=0; push 5 words with IN_VALID held.
   - Required: words 1-4 accepted, LEVEL=4, IN_READY=0, word 5 not accepted, S_valid stays 0.
   - Raise ENABLE: LEVEL drops to 3 one edge later and IN_READY returns to 1.
4. Stall: deassert ENABLE for 3 cycles after bit 2 of 4'b1101.
   - Required: S_output holds 1 and S_valid holds 1 for 3 cycles.
   - Resumes with 0,1; exactly 4 valid bits in total.
5. Reset mid-word: assert RST=0 after bit 2 of 4'b1011, with 2 words queued.
   - Required: S_valid=0 immediately (asynchronous), LEVEL=0, IN_READY=0, no WORD_DONE.
   - After release: IN_READY=1 and no stale bits are emitted.
6. MSB_FIRST=0; push 4'b1101.
   - Required: S_output = 1,0,1,1, so the detector sees 1011.
